// File: rtl/onewire_slot_engine.sv
// 1-Wire bit-slot engine: runs up to NUM_BITS read or write slots, LSB first, for the master FSM.
// A transfer takes nbits*SLOT_CYC cycles plus a one-cycle done pulse; start is only taken in IDLE and never queued.
module onewire_slot_engine #(
    parameter int CLK_PER_US  = 27,
    parameter int NUM_BITS    = 8,
    parameter int T_SLOT_US   = 70,
    parameter int T_DRIVE_US  = 6,
    parameter int T_W0_US     = 60,
    parameter int T_SAMPLE_US = 15,
    localparam int BW         = $clog2(NUM_BITS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic [BW-1:0]       nbits,
    input  logic [NUM_BITS-1:0] wr_data,
    input  logic                ow_in,
    output logic                drive_low,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] rd_data,
    output logic [BW-1:0]       bit_idx
);

    localparam int SLOT_CYC   = T_SLOT_US * CLK_PER_US;
    localparam int DRIVE_CYC  = T_DRIVE_US * CLK_PER_US;
    localparam int W0_CYC     = T_W0_US * CLK_PER_US;
    localparam int SAMPLE_CYC = T_SAMPLE_US * CLK_PER_US;
    localparam int CW         = $clog2(SLOT_CYC);

    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYC - 1);
    localparam logic [CW-1:0] DRV_C     = CW'(DRIVE_CYC);
    localparam logic [CW-1:0] W0_C      = CW'(W0_CYC);
    localparam logic [CW-1:0] SMP_C     = CW'(SAMPLE_CYC);
    localparam logic [BW-1:0] NB_MAX    = BW'(NUM_BITS);

    if (!(DRIVE_CYC < SAMPLE_CYC && SAMPLE_CYC < SLOT_CYC &&
          DRIVE_CYC < W0_CYC && W0_CYC < SLOT_CYC)) begin : g_bad_timing
        $error("onewire_slot_engine: slot timing parameters are inconsistent");
    end

    typedef enum logic [1:0] {IDLE, SLOT, FIN} state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [BW-1:0]       bit_idx_q;
    logic [BW-1:0]       nbits_q;
    logic                mode_q;
    logic [NUM_BITS-1:0] wr_q;
    logic [NUM_BITS-1:0] rd_q;
    logic                drive_q;
    logic                busy_q;
    logic                done_q;

    // Write-0 slots hold the bus low for most of the slot; everything else is a short pulse.
    function automatic logic [CW-1:0] low_cyc(input logic wr_mode, input logic wr_bit);
        return (wr_mode && !wr_bit) ? W0_C : DRV_C;
    endfunction

    logic [BW-1:0]       nb_clamp;
    logic [NUM_BITS-1:0] wr_shift_cur;
    logic [NUM_BITS-1:0] wr_shift_nxt;
    logic [CW-1:0]       cnt_inc;
    logic                last_slot;

    assign nb_clamp     = (nbits > NB_MAX) ? NB_MAX : nbits;
    assign wr_shift_cur = wr_q >> bit_idx_q;
    assign wr_shift_nxt = wr_q >> (bit_idx_q + BW'(1));
    assign cnt_inc      = cnt_q + CW'(1);
    assign last_slot    = (bit_idx_q == nbits_q - BW'(1));

    // drive_low is computed one cycle ahead so the pad sees a clean registered level.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            nbits_q   <= '0;
            mode_q    <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            drive_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q    <= mode;
                        wr_q      <= wr_data;
                        nbits_q   <= nb_clamp;
                        rd_q      <= '0;
                        bit_idx_q <= '0;
                        cnt_q     <= '0;
                        if (nb_clamp != '0) begin
                            state_q <= SLOT;
                            busy_q  <= 1'b1;
                            drive_q <= (low_cyc(mode, wr_data[0]) != '0);
                        end else begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                SLOT: begin
                    if (!mode_q && cnt_q == SMP_C) begin
                        rd_q <= rd_q | (NUM_BITS'(ow_in) << bit_idx_q);
                    end
                    if (cnt_q == SLOT_LAST) begin
                        cnt_q     <= '0;
                        bit_idx_q <= bit_idx_q + BW'(1);
                        if (last_slot) begin
                            state_q <= FIN;
                            busy_q  <= 1'b0;
                            drive_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            drive_q <= (low_cyc(mode_q, wr_shift_nxt[0]) != '0);
                        end
                    end else begin
                        cnt_q   <= cnt_inc;
                        drive_q <= (cnt_inc < low_cyc(mode_q, wr_shift_cur[0]));
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign drive_low = drive_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_data   = rd_q;
    assign bit_idx   = bit_idx_q;

endmodule
